// File: rtl/cic_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cic_mem_responder_pkg
//  Description : Shared bank-select encodings, phase states, default depths
//                and an address range helper for the CIC memory responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package cic_mem_responder_pkg;

    // Bank-select encoding shared by csel and chk_sel; 6 and 7 are illegal
    localparam logic [2:0] c_csel_none = 3'd0;
    localparam logic [2:0] c_csel_l0k0 = 3'd1;
    localparam logic [2:0] c_csel_l0k1 = 3'd2;
    localparam logic [2:0] c_csel_l1k0 = 3'd3;
    localparam logic [2:0] c_csel_l1k1 = 3'd4;
    localparam logic [2:0] c_csel_l2f  = 3'd5;

    localparam int c_img_depth = 4096;
    localparam int c_l0_depth  = 4096;
    localparam int c_l1_depth  = 1024;
    localparam int c_l2_depth  = 2048;

    typedef enum logic [1:0] {
        PH_LOAD  = 2'd0,
        PH_READY = 2'd1,
        PH_RUN   = 2'd2,
        PH_DONE  = 2'd3
    } phase_t;

    // A depth of 0 makes every address out of range (used for illegal selects)
    function automatic logic f_in_range(input logic [31:0] addr, input int depth);
        return addr < 32'(depth);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : cic_mem_responder_if
//  Description : Host-load, CIC pixel/result and check-port bus between the
//                host/CIC side (master) and the memory responder (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface cic_mem_responder_if #(
    parameter int DW = 20,
    parameter int AW = 12
);
    logic          img_we;
    logic [AW-1:0] img_waddr;
    logic [DW-1:0] img_wdata;
    logic          img_done;
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic [2:0]    csel;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          chk_rd;
    logic [2:0]    chk_sel;
    logic [AW-1:0] chk_addr;
    logic [DW-1:0] chk_data;
    logic          done;
    logic          err;

    modport master (
        output img_we, img_waddr, img_wdata, img_done, busy, iaddr,
               csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
               chk_rd, chk_sel, chk_addr,
        input  ready, idata, cdata_rd, chk_data, done, err
    );

    modport slave (
        input  img_we, img_waddr, img_wdata, img_done, busy, iaddr,
               csel, cwr, caddr_wr, cdata_wr, crd, caddr_rd,
               chk_rd, chk_sel, chk_addr,
        output ready, idata, cdata_rd, chk_data, done, err
    );
endinterface
`default_nettype wire

// File: rtl/cic_mem_responder_bank_ram.sv
`default_nettype none
// ============================================================================
//  Module      : cic_mem_responder_bank_ram
//  Description : Single-write, dual registered-read memory bank. Read data
//                holds when its enable is low; reads see the pre-write word.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_mem_responder_bank_ram #(
    parameter  int DEPTH = 4096,
    parameter  int DW    = 20,
    localparam int AB    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AB-1:0] wr_addr,
    input  wire logic [DW-1:0] wr_data,
    input  wire logic          a_en,
    input  wire logic [AB-1:0] a_addr,
    output      logic [DW-1:0] a_data,
    input  wire logic          b_en,
    input  wire logic [AB-1:0] b_addr,
    output      logic [DW-1:0] b_data
);
    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_a_data;
    logic [DW-1:0] r_b_data;

    // Write port
    always_ff @(posedge clk) begin
        if (we) r_mem[wr_addr] <= wr_data;
    end

    // Read port A (CIC side)
    always_ff @(posedge clk) begin
        if (a_en) r_a_data <= r_mem[a_addr];
    end

    // Read port B (host check side)
    always_ff @(posedge clk) begin
        if (b_en) r_b_data <= r_mem[b_addr];
    end

    assign a_data = r_a_data;
    assign b_data = r_b_data;
endmodule
`default_nettype wire

// File: rtl/cic_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cic_mem_responder
//  Description : Memory-side responder for the CIC engine: image store with
//                ready/busy pixel handshake, five csel-selected result banks,
//                an independent check port, run phase tracking and sticky err.
//  Revision    : 1.0 - initial release
// ============================================================================
module cic_mem_responder
    import cic_mem_responder_pkg::*;
#(
    parameter int DW        = 20,
    parameter int AW        = 12,
    parameter int IMG_DEPTH = c_img_depth,
    parameter int L0_DEPTH  = c_l0_depth,
    parameter int L1_DEPTH  = c_l1_depth,
    parameter int L2_DEPTH  = c_l2_depth
) (
    input wire logic         clk,
    input wire logic         reset,
    cic_mem_responder_if.slave bus
);
    localparam int c_img_ab = $clog2(IMG_DEPTH);

    function automatic int f_bank_depth(input logic [2:0] sel);
        case (sel)
            c_csel_l0k0, c_csel_l0k1: return L0_DEPTH;
            c_csel_l1k0, c_csel_l1k1: return L1_DEPTH;
            c_csel_l2f:               return L2_DEPTH;
            default:                  return 0;
        endcase
    endfunction

    phase_t        r_phase;
    logic          r_ready;
    logic          r_done;
    logic          r_idle;
    logic          r_err;
    logic          r_idata_zero;
    logic [2:0]    r_cq_sel;
    logic [2:0]    r_kq_sel;

    logic          w_pix_req;
    logic          w_pix_ok;
    logic          w_img_we;
    logic          w_cwr_ok;
    logic          w_crd_ok;
    logic          w_chk_ok;
    logic          w_err_evt;
    logic [DW-1:0] w_img_q;
    logic [DW-1:0] w_img_chk_unused;
    logic [DW-1:0] w_bank_cq [1:5];
    logic [DW-1:0] w_bank_kq [1:5];
    logic [DW-1:0] w_cdata;
    logic [DW-1:0] w_chk;

    assign w_pix_req = bus.busy && (r_phase != PH_LOAD);
    assign w_pix_ok  = f_in_range(32'(bus.iaddr), IMG_DEPTH);
    assign w_img_we  = bus.img_we && (r_phase == PH_LOAD)
                     && f_in_range(32'(bus.img_waddr), IMG_DEPTH);
    assign w_cwr_ok  = f_in_range(32'(bus.caddr_wr), f_bank_depth(bus.csel));
    assign w_crd_ok  = f_in_range(32'(bus.caddr_rd), f_bank_depth(bus.csel));
    assign w_chk_ok  = f_in_range(32'(bus.chk_addr), f_bank_depth(bus.chk_sel));

    assign w_err_evt = (bus.img_we && (r_phase != PH_LOAD))
                     | (bus.busy && (r_phase == PH_LOAD))
                     | (w_pix_req && !w_pix_ok)
                     | (bus.cwr && !w_cwr_ok)
                     | (bus.crd && !w_crd_ok);

    cic_mem_responder_bank_ram #(.DEPTH(IMG_DEPTH), .DW(DW)) u_img (
        .clk     (clk),
        .we      (w_img_we),
        .wr_addr (bus.img_waddr[c_img_ab-1:0]),
        .wr_data (bus.img_wdata),
        .a_en    (w_pix_req && w_pix_ok),
        .a_addr  (bus.iaddr[c_img_ab-1:0]),
        .a_data  (w_img_q),
        .b_en    (1'b0),
        .b_addr  ('0),
        .b_data  (w_img_chk_unused)
    );

    for (genvar b = 1; b <= 5; b++) begin : g_bank
        localparam int c_depth = f_bank_depth(3'(b));
        localparam int c_ab    = $clog2(c_depth);

        cic_mem_responder_bank_ram #(.DEPTH(c_depth), .DW(DW)) u_ram (
            .clk     (clk),
            .we      (bus.cwr && w_cwr_ok && (bus.csel == 3'(b))),
            .wr_addr (bus.caddr_wr[c_ab-1:0]),
            .wr_data (bus.cdata_wr),
            .a_en    (bus.crd && w_crd_ok && (bus.csel == 3'(b))),
            .a_addr  (bus.caddr_rd[c_ab-1:0]),
            .a_data  (w_bank_cq[b]),
            .b_en    (bus.chk_rd && w_chk_ok && (bus.chk_sel == 3'(b))),
            .b_addr  (bus.chk_addr[c_ab-1:0]),
            .b_data  (w_bank_kq[b])
        );
    end

    // Phase tracking: LOAD -> READY -> RUN -> DONE (one-cycle done pulse) -> LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_phase <= PH_LOAD;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_idle  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_phase)
                PH_LOAD: begin
                    if (bus.img_done) begin
                        r_phase <= PH_READY;
                        r_ready <= 1'b1;
                    end
                end
                PH_READY: begin
                    if (bus.busy) begin
                        r_phase <= PH_RUN;
                        r_ready <= 1'b0;
                        r_idle  <= 1'b0;
                    end
                end
                PH_RUN: begin
                    if (bus.busy) begin
                        r_idle <= 1'b0;
                    end else if (r_idle) begin
                        r_phase <= PH_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_idle <= 1'b1;
                    end
                end
                PH_DONE: r_phase <= PH_LOAD;
                default: r_phase <= PH_LOAD;
            endcase
        end
    end

    // Read-source tracking for the registered outputs, plus the sticky error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idata_zero <= 1'b1;
            r_cq_sel     <= c_csel_none;
            r_kq_sel     <= c_csel_none;
            r_err        <= 1'b0;
        end else begin
            if (bus.busy)   r_idata_zero <= !(w_pix_req && w_pix_ok);
            if (bus.crd)    r_cq_sel     <= w_crd_ok ? bus.csel : c_csel_none;
            if (bus.chk_rd) r_kq_sel     <= w_chk_ok ? bus.chk_sel : c_csel_none;
            if (w_err_evt)  r_err        <= 1'b1;
        end
    end

    // Bank output select; a "none" select yields zero
    always_comb begin
        w_cdata = '0;
        w_chk   = '0;
        for (int i = 1; i <= 5; i++) begin
            if (r_cq_sel == 3'(i)) w_cdata = w_bank_cq[i];
            if (r_kq_sel == 3'(i)) w_chk   = w_bank_kq[i];
        end
    end

    assign bus.ready    = r_ready;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.idata    = r_idata_zero ? '0 : w_img_q;
    assign bus.cdata_rd = w_cdata;
    assign bus.chk_data = w_chk;
endmodule
`default_nettype wire

// File: tb/tb_cic_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cic_mem_responder
//  Description : Self-checking bench for cic_mem_responder against a
//                behavioural memory/phase model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cic_mem_responder;
    localparam int DW = 20;
    localparam int AW = 12;
    localparam int M_LOAD  = 0;
    localparam int M_READY = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    cic_mem_responder_if #(.DW(DW), .AW(AW)) bus ();

    cic_mem_responder #(.DW(DW), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural model state
    logic [DW-1:0] img_m [4096];
    logic [DW-1:0] bank_m [int];
    int            ph;
    int            idle_cnt;
    logic          m_ready, m_done, m_err;
    logic [DW-1:0] m_idata, m_cdata, m_chk;
    int            n_vec = 0;
    int            n_err = 0;

    function automatic int depth_of(input int sel);
        case (sel)
            1, 2:    return 4096;
            3, 4:    return 1024;
            5:       return 2048;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input int sel, input int addr);
        return addr < depth_of(sel);
    endfunction

    function automatic int key(input int sel, input int addr);
        return sel * 65536 + addr;
    endfunction

    function automatic logic [DW-1:0] bank_get(input int sel, input int addr);
        if (bank_m.exists(key(sel, addr))) return bank_m[key(sel, addr)];
        return '0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ready"},    32'(bus.ready),    32'(m_ready));
        chk({tag, ".done"},     32'(bus.done),     32'(m_done));
        chk({tag, ".err"},      32'(bus.err),      32'(m_err));
        chk({tag, ".idata"},    32'(bus.idata),    32'(m_idata));
        chk({tag, ".cdata_rd"}, 32'(bus.cdata_rd), 32'(m_cdata));
        chk({tag, ".chk_data"}, 32'(bus.chk_data), 32'(m_chk));
    endtask

    task automatic idle_inputs();
        bus.img_we = 0; bus.img_waddr = '0; bus.img_wdata = '0; bus.img_done = 0;
        bus.busy = 0; bus.iaddr = '0;
        bus.csel = '0; bus.cwr = 0; bus.caddr_wr = '0; bus.cdata_wr = '0;
        bus.crd = 0; bus.caddr_rd = '0;
        bus.chk_rd = 0; bus.chk_sel = '0; bus.chk_addr = '0;
    endtask

    task automatic model_reset();
        ph = M_LOAD; idle_cnt = 0;
        m_ready = 0; m_done = 0; m_err = 0;
        m_idata = '0; m_cdata = '0; m_chk = '0;
    endtask

    // One clock: update the model from the current inputs, then advance the DUT
    task automatic cycle();
        bit ev = 0;
        int nph = ph;
        int sel = int'(bus.csel);
        if (bus.busy) begin
            if (ph == M_LOAD) begin m_idata = '0; ev = 1; end
            else if (int'(bus.iaddr) < 4096) m_idata = img_m[int'(bus.iaddr)];
            else begin m_idata = '0; ev = 1; end
        end
        if (bus.crd) begin
            if (legal(sel, int'(bus.caddr_rd))) m_cdata = bank_get(sel, int'(bus.caddr_rd));
            else begin m_cdata = '0; ev = 1; end
        end
        if (bus.chk_rd)
            m_chk = legal(int'(bus.chk_sel), int'(bus.chk_addr)) ?
                    bank_get(int'(bus.chk_sel), int'(bus.chk_addr)) : '0;
        if (bus.cwr) begin
            if (legal(sel, int'(bus.caddr_wr))) bank_m[key(sel, int'(bus.caddr_wr))] = bus.cdata_wr;
            else ev = 1;
        end
        if (bus.img_we) begin
            if (ph == M_LOAD) img_m[int'(bus.img_waddr)] = bus.img_wdata;
            else ev = 1;
        end
        case (ph)
            M_LOAD:  if (bus.img_done) nph = M_READY;
            M_READY: if (bus.busy) begin nph = M_RUN; idle_cnt = 0; end
            M_RUN: begin
                if (bus.busy) idle_cnt = 0;
                else begin
                    idle_cnt++;
                    if (idle_cnt == 2) nph = M_DONE;
                end
            end
            default: nph = M_LOAD;
        endcase
        if (ev) m_err = 1;
        ph = nph;
        m_ready = (ph == M_READY);
        m_done  = (ph == M_DONE);
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check outputs at once, then release after two edges
    task automatic apply_reset(input string tag);
        reset = 0;
        #1;
        model_reset();
        check_all(tag);
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        int s, a, j;
        logic [DW-1:0] d, keep0;
        int wq_sel[$];
        int wq_addr[$];

        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1;

        // Load image img[k] = k and hand it to CIC
        for (int k = 0; k < 4096; k++) begin
            bus.img_we = 1; bus.img_waddr = AW'(k); bus.img_wdata = DW'(k);
            cycle();
        end
        bus.img_we = 0; bus.img_done = 1;
        cycle();
        bus.img_done = 0;
        check_all("img_loaded");

        bus.busy = 1; bus.iaddr = 12'd63;
        cycle();
        check_all("first_pixel");
        for (int i = 0; i < 8; i++) begin
            bus.iaddr = AW'($urandom_range(0, 4095));
            cycle();
            check_all("rand_pixel");
        end

        // Same-cycle write and read on one bank word
        bus.cwr = 1; bus.csel = 3'd1; bus.caddr_wr = 12'd5; bus.cdata_wr = 20'h11;
        cycle();
        bus.crd = 1; bus.caddr_rd = 12'd5; bus.cdata_wr = 20'h22;
        cycle();
        check_all("collide_old");
        bus.cwr = 0;
        cycle();
        check_all("collide_new");
        bus.crd = 0;

        // Random legal traffic across all banks
        for (int i = 0; i < 24; i++) begin
            bus.cwr = 0; bus.crd = 0; bus.chk_rd = 0;
            bus.iaddr = AW'($urandom_range(0, 4095));
            if (i % 2 == 0 || wq_sel.size() == 0) begin
                s = $urandom_range(1, 5);
                a = $urandom_range(0, depth_of(s) - 1);
                bus.cwr = 1; bus.csel = 3'(s); bus.caddr_wr = AW'(a);
                bus.cdata_wr = DW'($urandom);
                wq_sel.push_back(s); wq_addr.push_back(a);
            end else begin
                j = $urandom_range(0, wq_sel.size() - 1);
                bus.crd = 1; bus.csel = 3'(wq_sel[j]); bus.caddr_rd = AW'(wq_addr[j]);
                j = $urandom_range(0, wq_sel.size() - 1);
                bus.chk_rd = 1; bus.chk_sel = 3'(wq_sel[j]); bus.chk_addr = AW'(wq_addr[j]);
            end
            cycle();
            check_all("rand_bank");
        end
        bus.cwr = 0; bus.crd = 0; bus.chk_rd = 0;

        // End of run: two idle cycles, one done pulse, back to LOAD
        bus.busy = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check_all("run_end");
        end

        // L1K0 top address accepted, one past it rejected
        d = DW'($urandom);
        bus.cwr = 1; bus.csel = 3'd3; bus.caddr_wr = 12'd0; bus.cdata_wr = d;
        cycle();
        bus.caddr_wr = 12'd1023; bus.cdata_wr = 20'hABCDE;
        cycle();
        bus.cwr = 0; bus.crd = 1; bus.caddr_rd = 12'd1023;
        cycle();
        check_all("l1_top_ok");
        bus.crd = 0; bus.cwr = 1; bus.caddr_wr = 12'd1024; bus.cdata_wr = ~d;
        cycle();
        bus.cwr = 0; bus.chk_rd = 1; bus.chk_sel = 3'd3; bus.chk_addr = 12'd0;
        cycle();
        check_all("l1_overflow");
        bus.chk_rd = 0;

        // Illegal selects must not touch any bank
        apply_reset("rst_a");
        for (int b = 1; b <= 5; b++) begin
            bus.cwr = 1; bus.csel = 3'(b); bus.caddr_wr = 12'd7; bus.cdata_wr = DW'($urandom);
            cycle();
        end
        check_all("bank_prefill");
        bus.csel = 3'd0; bus.cdata_wr = DW'($urandom);
        cycle();
        bus.csel = 3'd7; bus.cdata_wr = DW'($urandom);
        cycle();
        bus.cwr = 0;
        for (int b = 1; b <= 5; b++) begin
            bus.chk_rd = 1; bus.chk_sel = 3'(b); bus.chk_addr = 12'd7;
            cycle();
            check_all("illegal_csel");
        end
        bus.chk_rd = 0;

        // busy while still loading: zero pixel, error
        apply_reset("rst_b");
        bus.busy = 1; bus.iaddr = 12'd100;
        cycle();
        check_all("busy_in_load");

        // img_we during RUN is ignored and flagged
        apply_reset("rst_c");
        bus.img_done = 1;
        cycle();
        bus.img_done = 0; bus.busy = 1; bus.iaddr = 12'd10;
        cycle();
        check_all("run2_start");
        bus.img_we = 1; bus.img_waddr = 12'd63; bus.img_wdata = 20'h55555;
        cycle();
        check_all("img_we_in_run");
        bus.img_we = 0; bus.iaddr = 12'd63;
        cycle();
        check_all("img_unchanged");

        // Reset in the middle of RUN; banks survive
        apply_reset("rst_mid_run");
        bus.chk_rd = 1; bus.chk_sel = 3'd3; bus.chk_addr = 12'd1023;
        cycle();
        check_all("post_rst_l1");
        bus.chk_sel = 3'd1; bus.chk_addr = 12'd5;
        cycle();
        check_all("post_rst_l0");
        bus.chk_rd = 0;
        cycle();
        check_all("post_rst_idle");

        keep0 = d;
        chk("l1_addr0_kept", 32'(bank_get(3, 0)), 32'(keep0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
